// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module     : riscv_pkg
// Description: Shared widths, control-bundle layout and ALU opcode classes
//              for the 8-bit RISC-V pipeline registers.
// Revision   : 1.0 - initial release
// ============================================================================
package riscv_pkg;

   localparam int DATA_W = 8;
   localparam int REG_AW = 5;

   // ALU operation class handed to ALU_Control
   localparam logic [1:0] ALU_OP_LDST   = 2'b00;
   localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
   localparam logic [1:0] ALU_OP_RTYPE  = 2'b10;

   // Control bundle, MSB first: WB controls, MEM controls, EX controls
   typedef struct packed {
      logic       reg_write;
      logic       mem_to_reg;
      logic       mem_read;
      logic       mem_write;
      logic       branch;
      logic       alu_src;
      logic [1:0] alu_op;
   } ctrl_t;

   localparam int CTRL_W = $bits(ctrl_t);

   // A bubble carries no side effects: every control bit low, alu_op = LDST
   localparam ctrl_t CTRL_NOP = '0;

   // Control fields only survive when the instruction is real
   function automatic ctrl_t ctrl_gate(input ctrl_t c, input logic valid);
      return valid ? c : CTRL_NOP;
   endfunction

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/pipe_field.sv
`default_nettype none
// ============================================================================
// Module     : pipe_field
// Description: Generic pipeline-register field group. Reset and flush load
//              CLR_VAL, stall holds, otherwise the input is captured.
//              Shared by the ID/EX, EX/MEM and MEM/WB registers.
// Revision   : 1.0 - initial release
// ============================================================================
module pipe_field #(
   parameter int           W       = 8,
   parameter logic [W-1:0] CLR_VAL = '0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         stall_i,
   input  logic         flush_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] field_q;
   logic [W-1:0] field_d;

   // Next value: flush beats stall, stall holds, otherwise load
   always_comb begin
      field_d = d_i;
      if (flush_i) begin
         field_d = CLR_VAL;
      end else if (stall_i) begin
         field_d = field_q;
      end
   end

   // Register with synchronous reset overriding flush and stall
   always_ff @(posedge clk) begin
      if (reset) begin
         field_q <= CLR_VAL;
      end else begin
         field_q <= field_d;
      end
   end

   assign q_o = field_q;

endmodule : pipe_field
`default_nettype wire

// File: rtl/id_ex_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module     : id_ex_pipe_reg
// Description: ID/EX pipeline register. Captures decoded control, operands,
//              immediate, register indices and {funct7,funct3}; supports
//              load-use stall and bubble insertion, with valid/bubble flags.
// Revision   : 1.0 - initial release
// ============================================================================
module id_ex_pipe_reg #(
   parameter int DATA_W = 8,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              flush,
   input  logic              id_valid,
   input  logic              id_reg_write,
   input  logic              id_mem_to_reg,
   input  logic              id_mem_read,
   input  logic              id_mem_write,
   input  logic              id_branch,
   input  logic              id_alu_src,
   input  logic [1:0]        id_alu_op,
   input  logic [9:0]        id_funct,
   input  logic [DATA_W-1:0] id_pc,
   input  logic [DATA_W-1:0] id_rs1_data,
   input  logic [DATA_W-1:0] id_rs2_data,
   input  logic [DATA_W-1:0] id_imm,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic [REG_AW-1:0] id_rd,
   output logic              ex_valid,
   output logic              ex_reg_write,
   output logic              ex_mem_to_reg,
   output logic              ex_mem_read,
   output logic              ex_mem_write,
   output logic              ex_branch,
   output logic              ex_alu_src,
   output logic [1:0]        ex_alu_op,
   output logic [9:0]        ex_funct,
   output logic [DATA_W-1:0] ex_pc,
   output logic [DATA_W-1:0] ex_rs1_data,
   output logic [DATA_W-1:0] ex_rs2_data,
   output logic [DATA_W-1:0] ex_imm,
   output logic [REG_AW-1:0] ex_rs1,
   output logic [REG_AW-1:0] ex_rs2,
   output logic [REG_AW-1:0] ex_rd,
   output logic              ex_is_bubble
);

   import riscv_pkg::*;

   localparam int CTL_GRP_W  = 1 + 10 + CTRL_W;
   localparam int DATA_GRP_W = 4 * DATA_W;
   localparam int IDX_GRP_W  = 3 * REG_AW;

   ctrl_t                 id_ctrl;
   ctrl_t                 ex_ctrl;
   logic [CTL_GRP_W-1:0]  ctl_grp_d;
   logic [CTL_GRP_W-1:0]  ctl_grp_q;
   logic [DATA_GRP_W-1:0] data_grp_d;
   logic [DATA_GRP_W-1:0] data_grp_q;
   logic [IDX_GRP_W-1:0]  idx_grp_d;
   logic [IDX_GRP_W-1:0]  idx_grp_q;

   // Bundle the decoded controls; an invalid instruction is loaded as a NOP
   always_comb begin
      id_ctrl            = CTRL_NOP;
      id_ctrl.reg_write  = id_reg_write;
      id_ctrl.mem_to_reg = id_mem_to_reg;
      id_ctrl.mem_read   = id_mem_read;
      id_ctrl.mem_write  = id_mem_write;
      id_ctrl.branch     = id_branch;
      id_ctrl.alu_src    = id_alu_src;
      id_ctrl.alu_op     = id_alu_op;
      ctl_grp_d          = {id_valid, id_funct, ctrl_gate(id_ctrl, id_valid)};
      data_grp_d         = {id_pc, id_rs1_data, id_rs2_data, id_imm};
      idx_grp_d          = {id_rs1, id_rs2, id_rd};
   end

   pipe_field #(.W(CTL_GRP_W), .CLR_VAL('0)) u_ctl (
      .clk     (clk),
      .reset   (reset),
      .stall_i (stall),
      .flush_i (flush),
      .d_i     (ctl_grp_d),
      .q_o     (ctl_grp_q)
   );

   pipe_field #(.W(DATA_GRP_W), .CLR_VAL('0)) u_data (
      .clk     (clk),
      .reset   (reset),
      .stall_i (stall),
      .flush_i (flush),
      .d_i     (data_grp_d),
      .q_o     (data_grp_q)
   );

   pipe_field #(.W(IDX_GRP_W), .CLR_VAL('0)) u_idx (
      .clk     (clk),
      .reset   (reset),
      .stall_i (stall),
      .flush_i (flush),
      .d_i     (idx_grp_d),
      .q_o     (idx_grp_q)
   );

   // Bubble flag: set by reset/flush, cleared by any normal load
   pipe_field #(.W(1), .CLR_VAL(1'b1)) u_bubble (
      .clk     (clk),
      .reset   (reset),
      .stall_i (stall),
      .flush_i (flush),
      .d_i     (1'b0),
      .q_o     (ex_is_bubble)
   );

   assign {ex_valid, ex_funct, ex_ctrl}              = ctl_grp_q;
   assign {ex_pc, ex_rs1_data, ex_rs2_data, ex_imm}  = data_grp_q;
   assign {ex_rs1, ex_rs2, ex_rd}                    = idx_grp_q;

   assign ex_reg_write  = ex_ctrl.reg_write;
   assign ex_mem_to_reg = ex_ctrl.mem_to_reg;
   assign ex_mem_read   = ex_ctrl.mem_read;
   assign ex_mem_write  = ex_ctrl.mem_write;
   assign ex_branch     = ex_ctrl.branch;
   assign ex_alu_src    = ex_ctrl.alu_src;
   assign ex_alu_op     = ex_ctrl.alu_op;

endmodule : id_ex_pipe_reg
`default_nettype wire

// File: tb/tb_id_ex_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module     : tb_id_ex_pipe_reg
// Description: Scoreboard bench for id_ex_pipe_reg with directed and random
//              stimulus against a rule-level reference model.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_id_ex_pipe_reg;

   typedef struct packed {
      logic       valid;
      logic       reg_write;
      logic       mem_to_reg;
      logic       mem_read;
      logic       mem_write;
      logic       branch;
      logic       alu_src;
      logic [1:0] alu_op;
      logic [9:0] funct;
      logic [7:0] pc;
      logic [7:0] rs1_data;
      logic [7:0] rs2_data;
      logic [7:0] imm;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
   } fields_t;

   typedef struct packed {
      logic    reset;
      logic    stall;
      logic    flush;
      fields_t f;
   } stim_t;

   typedef struct packed {
      fields_t f;
      logic    bubble;
   } exp_t;

   logic  clk = 1'b0;
   stim_t stim = '0;
   exp_t  model_q = '0;
   exp_t  sb[$];
   int    checks = 0;
   int    failures = 0;

   logic       ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_read;
   logic       ex_mem_write, ex_branch, ex_alu_src, ex_is_bubble;
   logic [1:0] ex_alu_op;
   logic [9:0] ex_funct;
   logic [7:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
   logic [4:0] ex_rs1, ex_rs2, ex_rd;

   always #5 clk = ~clk;

   id_ex_pipe_reg #(.DATA_W(8), .REG_AW(5)) dut (
      .clk           (clk),
      .reset         (stim.reset),
      .stall         (stim.stall),
      .flush         (stim.flush),
      .id_valid      (stim.f.valid),
      .id_reg_write  (stim.f.reg_write),
      .id_mem_to_reg (stim.f.mem_to_reg),
      .id_mem_read   (stim.f.mem_read),
      .id_mem_write  (stim.f.mem_write),
      .id_branch     (stim.f.branch),
      .id_alu_src    (stim.f.alu_src),
      .id_alu_op     (stim.f.alu_op),
      .id_funct      (stim.f.funct),
      .id_pc         (stim.f.pc),
      .id_rs1_data   (stim.f.rs1_data),
      .id_rs2_data   (stim.f.rs2_data),
      .id_imm        (stim.f.imm),
      .id_rs1        (stim.f.rs1),
      .id_rs2        (stim.f.rs2),
      .id_rd         (stim.f.rd),
      .ex_valid      (ex_valid),
      .ex_reg_write  (ex_reg_write),
      .ex_mem_to_reg (ex_mem_to_reg),
      .ex_mem_read   (ex_mem_read),
      .ex_mem_write  (ex_mem_write),
      .ex_branch     (ex_branch),
      .ex_alu_src    (ex_alu_src),
      .ex_alu_op     (ex_alu_op),
      .ex_funct      (ex_funct),
      .ex_pc         (ex_pc),
      .ex_rs1_data   (ex_rs1_data),
      .ex_rs2_data   (ex_rs2_data),
      .ex_imm        (ex_imm),
      .ex_rs1        (ex_rs1),
      .ex_rs2        (ex_rs2),
      .ex_rd         (ex_rd),
      .ex_is_bubble  (ex_is_bubble)
   );

   // Reference: the ID/EX slot contents after one edge, from the stage rules
   function automatic exp_t model_next(input exp_t prev, input stim_t s);
      exp_t n;
      n = prev;
      if (s.reset || s.flush) begin
         n.f      = '0;
         n.bubble = 1'b1;
      end else if (!s.stall) begin
         n.f      = s.f;
         n.bubble = 1'b0;
         if (!s.f.valid) begin
            n.f.reg_write  = 1'b0;
            n.f.mem_to_reg = 1'b0;
            n.f.mem_read   = 1'b0;
            n.f.mem_write  = 1'b0;
            n.f.branch     = 1'b0;
            n.f.alu_src    = 1'b0;
            n.f.alu_op     = 2'b00;
         end
      end
      return n;
   endfunction

   function automatic stim_t rnd_stim();
      stim_t s;
      s          = '0;
      s.f        = fields_t'({$urandom, $urandom, $urandom});
      s.f.valid  = ($urandom_range(0, 9) < 8);
      return s;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Stimulus: apply at the falling edge and push the predicted EX slot
   task automatic drive(input stim_t s);
      @(negedge clk);
      stim    = s;
      model_q = model_next(model_q, s);
      sb.push_back(model_q);
   endtask

   // Monitor: the register presents a slot every cycle; compare after the edge
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("ctrl", 64'({ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write,
                               ex_branch, ex_alu_src, ex_alu_op}),
                          64'({e.f.reg_write, e.f.mem_to_reg, e.f.mem_read, e.f.mem_write,
                               e.f.branch, e.f.alu_src, e.f.alu_op}));
            check("valid_bubble", 64'({ex_valid, ex_is_bubble}), 64'({e.f.valid, e.bubble}));
            check("funct", 64'(ex_funct), 64'(e.f.funct));
            check("data", 64'({ex_pc, ex_rs1_data, ex_rs2_data, ex_imm}),
                          64'({e.f.pc, e.f.rs1_data, e.f.rs2_data, e.f.imm}));
            check("index", 64'({ex_rs1, ex_rs2, ex_rd}), 64'({e.f.rs1, e.f.rs2, e.f.rd}));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      stim_t s;

      // Reset held two cycles with arbitrary ID contents
      for (int i = 0; i < 2; i++) begin
         s = rnd_stim(); s.reset = 1'b1; drive(s);
      end
      // Release with an R-type SUB encoding
      s = rnd_stim(); s.f.valid = 1'b1; s.f.alu_op = 2'b10; s.f.funct = 10'b0100000000;
      drive(s);

      // Streaming load: fixed pattern, then a new value every cycle
      s = rnd_stim(); s.f.valid = 1'b1; s.f.rs1_data = 8'hA5; s.f.imm = 8'hFF;
      s.f.rd = 5'd7; s.f.reg_write = 1'b1;
      drive(s);
      for (int i = 0; i < 10; i++) begin
         s = rnd_stim(); drive(s);
      end

      // Stall for three cycles while ID keeps changing, then release
      for (int i = 0; i < 3; i++) begin
         s = rnd_stim(); s.stall = 1'b1; drive(s);
      end
      s = rnd_stim(); drive(s);

      // Flush a store to x9, then flush and stall together
      s = rnd_stim(); s.f.valid = 1'b1; s.f.mem_write = 1'b1; s.f.rd = 5'd9; s.flush = 1'b1;
      drive(s);
      s = rnd_stim(); drive(s);
      s = rnd_stim(); s.flush = 1'b1; s.stall = 1'b1; drive(s);

      // Invalid instruction carrying live-looking controls
      s = rnd_stim(); s.f.valid = 1'b0; s.f.reg_write = 1'b1; s.f.alu_op = 2'b01;
      drive(s);

      // Reset pulsed in the middle of a stall
      s = rnd_stim(); drive(s);
      s = rnd_stim(); s.stall = 1'b1; drive(s);
      s = rnd_stim(); s.stall = 1'b1; s.reset = 1'b1; drive(s);
      s = rnd_stim(); s.stall = 1'b1; drive(s);
      s = rnd_stim(); drive(s);

      // Random traffic with mixed control activity
      for (int i = 0; i < 400; i++) begin
         s       = rnd_stim();
         s.reset = ($urandom_range(0, 49) == 0);
         s.flush = ($urandom_range(0, 9) == 0);
         s.stall = ($urandom_range(0, 3) == 0);
         drive(s);
      end

      @(negedge clk);
      @(negedge clk);
      check("scoreboard_drain", 64'(sb.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_id_ex_pipe_reg
`default_nettype wire

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
- ID/EX pipeline register of the 8-bit RISC-V pipeline.
- Captures decoded control, operands, immediate, register indices and {funct7,funct3} from the ID stage on each clock edge.
- Presents them to EX, where alu_op and funct feed ALU_Control and the operands feed the ALU.
- Supports hold (load-use stall) and bubble insertion (branch/hazard flush); carries a valid bit so downstream logic can tell real instructions from bubbles.

Parameters:
- DATA_W, 8, width of the register-file operands, immediate and PC.
- REG_AW, 5, width of the rs1/rs2/rd register indices.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold all ID/EX contents this cycle.
- flush  in  1  load a bubble this cycle.
- id_valid  in  1  ID holds a real instruction.
- id_reg_write  in  1  WB control.
- id_mem_to_reg  in  1  WB control.
- id_mem_read  in  1  MEM control.
- id_mem_write  in  1  MEM control.
- id_branch  in  1  MEM control.
- id_alu_src  in  1  EX control, 1 = immediate operand.
- id_alu_op  in  2  EX control, to ALU_Control.
- id_funct  in  10  {funct7, funct3}.
- id_pc  in  DATA_W  instruction PC.
- id_rs1_data  in  DATA_W  register-file read port 1.
- id_rs2_data  in  DATA_W  register-file read port 2.
- id_imm  in  DATA_W  sign-extended immediate.
- id_rs1  in  REG_AW  source index 1.
- id_rs2  in  REG_AW  source index 2.
- id_rd  in  REG_AW  destination index.
- ex_*  out  (same widths)  registered copy of every id_* input above, including ex_valid.
- ex_is_bubble  out  1  registered; 1 when the current EX slot was produced by reset or flush.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset:
  - Every ex_* output is 0, including ex_alu_op = 2'b00 (ALU_Control decodes ADD, harmless).
  - ex_valid = 0, ex_is_bubble = 1.
  - Reset asserted mid-stall or mid-flush overrides both on that edge.
- Latency: exactly 1 cycle from id_* to ex_*. No combinational path from any input to any output.
- Priority per rising edge: reset > flush > stall > normal load.
- Normal load (no reset/flush/stall):
  - All ex_* take their id_* values; ex_is_bubble = 0.
  - ex_valid = id_valid.
- Stall:
  - All ex_* and ex_is_bubble hold their previous values.
  - Multi-cycle stalls hold indefinitely.
- Flush (stall ignored when both asserted):
  - Control fields forced to 0: reg_write, mem_to_reg, mem_read, mem_write, branch, alu_src, alu_op.
  - ex_funct = 0 and ex_valid = 0; ex_is_bubble = 1.
  - ex_rd = 0, so forwarding never matches x0.
  - Data fields (pc, rs1_data, rs2_data, imm, rs1, rs2) are also zeroed, for deterministic waveforms.
- Invalid instruction load: id_valid = 0 without flush loads normally but also forces the control fields to 0, same as a bubble. ex_is_bubble = 0 in this case.
- Width rule: pure pass-through. No arithmetic, extension or truncation.
- No internal state beyond the pipeline registers. No FSM; the stage state is {valid, bubble}.

Decomposition:
- Shared package (riscv_pkg):
  - DATA_W and REG_AW.
  - Control-bundle field order.
  - ALU_OP_LDST = 2'b00, ALU_OP_BRANCH = 2'b01, ALU_OP_RTYPE = 2'b10.
  - The NOP/bubble control constant (all zeros).
- Sub-module pipe_field (parameterised width, with reset/flush/stall enable):
  - One instance per field group: control, data, index.
  - The same cell is reused for the EX/MEM and MEM/WB registers.

Test Plan:
- Reset → all-zero outputs: hold reset for 2 cycles with arbitrary id_* → after the edge, all ex_* = 0, ex_valid = 0, ex_is_bubble = 1. Release reset with id_alu_op = 2'b10, id_funct = 10'b0100000000 → next edge ex_alu_op = 2'b10, ex_funct = 10'h100.
- Streaming load: drive id_rs1_data = 8'hA5, id_imm = 8'hFF, id_rd = 5'd7, id_reg_write = 1 → each value appears on ex_* exactly 1 cycle later. A new value every cycle for 10 cycles is tracked cycle-for-cycle.
- Stall hold: assert stall for 3 cycles while the id_* values change → ex_* keep the pre-stall values for all 3 cycles. The first post-stall edge loads the current id_*.
- Flush inserts a bubble: flush with id_mem_write = 1, id_rd = 5'd9 → ex_mem_write = 0, ex_rd = 0, ex_valid = 0, ex_is_bubble = 1. Assert flush and stall together → same bubble (flush wins).
- Invalid instruction: id_valid = 0 with id_reg_write = 1 and id_alu_op = 2'b01 → ex_reg_write = 0, ex_alu_op = 0, ex_is_bubble = 0.
- Reset during stall: stall high, then reset pulsed for 1 cycle → outputs reach the reset values on that edge despite the stall.
